mult_16_bit_seq: RTL
====================

# mult_16_bit_seq

Sequential unsigned 16x16 multiplier built around a single `adder_16_bit` instance, which it reuses once per cycle in a shift-add loop. It sits beside the ALU as a multi-cycle functional unit. The core issues a `Start` pulse and then waits on `Busy`/`Done`. This block is the only owner and sequencer of its adder instance.

## Interface
- Parameters: none. Operand width is fixed at 16 by the adder datapath.
- `clk`  in  1  Single clock; all state updates on its rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `Start`  in  1  Request. Accepted only on an edge where `Busy`=0.
- `A`  in  16  Multiplicand; sampled on the accepting edge only.
- `B`  in  16  Multiplier; sampled on the accepting edge only.
- `Busy`  out  1  High while iterating (state RUN).
- `Done`  out  1  One-cycle pulse: `Product` is valid for the new result.
- `Product`  out  32  Unsigned A*B. Held stable until the next accepted `Start`.
- `Overflow`  out  1  High when `Product[31:16]` != 0. Registered together with `Product`.

## Operation
- Internal registers:
  - `M[15:0]`: latched A.
  - `P_hi[15:0]`: partial product.
  - `P_lo[15:0]`: multiplier, shifting out as product low bits.
  - `Cnt[4:0]`: iteration counter.
  - `State`.
- States: IDLE, RUN, DONE.
  - IDLE, Start=1: go to RUN; M<=A, P_lo<=B, P_hi<=0, Cnt<=0.
  - IDLE, Start=0: stay in IDLE.
  - RUN, each edge:
    - Drive adder with A=P_hi, B=(P_lo[0] ? M : 16'h0000), Cin=0.
    - Then {P_hi,P_lo} <= {Cout, S, P_lo[15:1]}, and Cnt<=Cnt+1.
    - When Cnt==15 on that edge, go to DONE.
  - DONE: Product <= {P_hi,P_lo} and Overflow are loaded on the RUN->DONE edge. Done=1 for this single cycle.
    - Start=1 in DONE is accepted: same loads as IDLE, next state RUN (back-to-back operation).
    - Otherwise go to IDLE.
- `Start` while `Busy`=1 is ignored. No queuing; A/B changes have no effect.
- Adder is always exercised in RUN, even when P_lo[0]=0 (B operand forced to 0). The adder carry-out is the 17th bit of each partial sum and must never be dropped.
- Arithmetic: unsigned only. The result is exact for all 2^32 operand pairs, so no truncation occurs.

## Timing
- Reset (rst_n=0, any time, including mid-RUN), asynchronously:
  - State=IDLE, Busy=0, Done=0, Product=0, Overflow=0, and all internal registers 0.
  - An in-flight operation is discarded with no `Done`.
- Accepting edge E0 (Start=1, Busy=0). Busy=1 from E0 until E16.
- Edges E1..E16 each perform one iteration; the 16th iteration occurs at E16.
- State is DONE after E16, so Done=1 in the cycle between E16 and E17.
- Latency: `Done` asserts 16 clocks after the accepting edge. A back-to-back start gives a throughput of one result per 17 clocks.
- `Busy` and `Done` are never high together. `Busy` falls on the same edge `Done` rises.
- Outputs are all registered or decoded from `State`. `Start`, `A` and `B` have no combinational path to any output.
- rst_n deassertion: the first edge after it may accept `Start`.

## Test plan
- Basic case:
  - Stimulus: A=3, B=5, Start pulsed one cycle.
  - Required: Busy high 16 cycles; Done pulses once; Product=32'h0000000F; Overflow=0; Product holds after Done.
- Max operands:
  - Stimulus: A=16'hFFFF, B=16'hFFFF.
  - Required: Product=32'hFFFE0001, Overflow=1. This checks carry-out propagation every iteration.
- Zero and identity:
  - Stimulus: A=0, B=16'h1234, then A=16'h8001, B=1.
  - Required: Product=0 then 32'h00008001, each with latency 16.
- Start ignored while busy:
  - Stimulus: A=7, B=9 accepted; at E5 present Start=1 with A=2, B=2.
  - Required: single Done at E16; Product=63; no second operation.
- Reset mid-operation:
  - Stimulus: start A=100, B=200; drop rst_n between E8 and E9, release, then start A=100, B=200 again.
  - Required: all outputs 0 immediately on reset; no Done from the first run; second run Product=20000.
- Back-to-back:
  - Stimulus: hold Start=1 with A=16'h00FF, B=16'h0100 during the DONE cycle of a prior 2*3 operation.
  - Required: first Product=6; Busy re-asserts with no idle cycle; second Done 16 clocks later with Product=32'h0000FF00.

Source files
------------

// File: rtl/mult_16_bit_seq.sv
// -----------------------------------------------------------------------------
// mult_16_bit_seq
//
// Sequential unsigned 16x16 multiplier. One 16-bit adder is reused once per
// clock in a shift-add loop, so a full product takes 16 iterations. It works
// as a multi-cycle functional unit beside the ALU: the core pulses Start and
// then watches Busy/Done.
//
// Ports (mult_16_bit_seq):
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   Start     in   1   request, accepted only while Busy is low
//   A         in  16   multiplicand, sampled on the accepting edge
//   B         in  16   multiplier, sampled on the accepting edge
//   Busy      out  1   high while iterating
//   Done      out  1   one-cycle pulse, Product holds a new result
//   Product   out 32   unsigned A*B, held until the next accepted Start
//   Overflow  out  1   Product[31:16] is non-zero, registered with Product
//
// Ports (adder_16_bit):
//   a, b      in  16   addends
//   cin       in   1   carry in
//   s         out 16   sum
//   cout      out  1   carry out (17th bit of the sum)
// -----------------------------------------------------------------------------

module adder_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

module mult_16_bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic        Overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [15:0] m;
    logic [15:0] p_hi;
    logic [15:0] p_lo;
    logic [4:0]  cnt;

    logic        accept;
    logic        last_iter;

    logic [15:0] add_b;
    logic [15:0] add_s;
    logic        add_cout;
    logic [31:0] iter_result;

    // The adder runs every RUN cycle; a zero multiplier bit just adds zero.
    assign add_b = p_lo[0] ? m : 16'h0000;

    adder_16_bit u_adder (
        .a    (p_hi),
        .b    (add_b),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // Carry-out becomes the new top bit, so no partial sum bit is lost; the
    // multiplier shifts right and its vacated bits collect product low bits.
    assign iter_result = {add_cout, add_s, p_lo[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and decoded outputs. DONE may accept a new request directly
    // so back-to-back operations lose no cycle to IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == 5'd15) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. Product/Overflow are only written on the final
    // iteration, so they stay stable through the whole next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        <= 16'd0;
            p_hi     <= 16'd0;
            p_lo     <= 16'd0;
            cnt      <= 5'd0;
            Product  <= 32'd0;
            Overflow <= 1'b0;
        end else if (accept) begin
            m    <= A;
            p_lo <= B;
            p_hi <= 16'd0;
            cnt  <= 5'd0;
        end else if (state == RUN) begin
            {p_hi, p_lo} <= iter_result;
            cnt          <= cnt + 5'd1;
            if (last_iter) begin
                Product  <= iter_result;
                Overflow <= (iter_result[31:16] != 16'd0);
            end
        end
    end

endmodule
